pwm_width_meter: RTL and testbench
==================================

PWM_WIDTH_METER -- requirements
Module: pwm_width_meter

Interface
REQ-001 The block SHALL have parameter W, default 12, which sets the width of the measurement counters and of the result outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 4095, which is the number of cycles with no edge before a measurement is abandoned; TIMEOUT SHALL be at most 2^W-1.
REQ-003 clk  input  1  core clock; every flop is in this single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  measurement enable; when low, counters and the state machine hold.
REQ-006 signal  input  1  PWM output from the switch driver; asynchronous to clk.
REQ-007 period  output  W  clk cycles between two consecutive detected rising edges.
REQ-008 high_time  output  W  clk cycles from a detected rising edge to the next detected falling edge.
REQ-009 valid  output  1  result available in the period/high_time register.
REQ-010 ready  input  1  consumer accepts the result.
REQ-011 overrun  output  1  sticky flag; a new result arrived while the previous one was still unaccepted.
REQ-012 stuck  output  1  level flag; no edge seen within TIMEOUT cycles.
REQ-013 stuck_level  output  1  synchronized value of signal at the moment stuck was set.

Function
REQ-014 signal SHALL pass through a 2-flop synchronizer plus one history flop. rise and fall SHALL be single-cycle pulses, giving 3 clk cycles of latency from the pad to the pulse.
REQ-015 The FSM states SHALL be IDLE, HIGH, LOW and STUCK.
REQ-016 IDLE SHALL go to HIGH on rise. Any fall seen in IDLE SHALL be ignored.
REQ-017 HIGH SHALL go to LOW on fall. On that transition hi_cnt SHALL be latched into a shadow register.
REQ-018 LOW SHALL go to HIGH on rise. On that transition {per_cnt, shadow} SHALL be published as one result.
REQ-019 per_cnt and hi_cnt SHALL load 1 in the cycle of rise and increment once per enabled cycle after that. hi_cnt SHALL stop after fall. Both counters SHALL saturate at 2^W-1 and never wrap.
REQ-020 The published period SHALL equal the number of cycles between rise pulses. The published high_time SHALL equal the number of cycles between the rise pulse and the fall pulse.
REQ-021 In HIGH or LOW, if per_cnt reaches TIMEOUT, the FSM SHALL go to STUCK and set stuck=1 and stuck_level. No result SHALL be published.
REQ-022 STUCK SHALL go to HIGH on rise, which clears stuck and restarts counting. A fall in STUCK SHALL go to IDLE and clear stuck.
REQ-023 Handshake: a transfer occurs when valid=1 and ready=1 in the same cycle.
REQ-024 valid SHALL rise in the cycle after a publish. It SHALL stay high, with data stable, until a transfer.
REQ-025 If a publish and a transfer occur in the same cycle, the new result SHALL load, valid SHALL stay 1, and overrun SHALL NOT set.
REQ-026 If a publish occurs while valid=1 and ready=0, the new result SHALL overwrite the old one and overrun SHALL set to 1. overrun SHALL clear only by reset.
REQ-027 When en=0, the synchronizer SHALL keep running, the FSM and counters SHALL hold, and edges during that time SHALL be lost.
REQ-028 The output handshake SHALL keep operating while en=0.
REQ-029 The first result after reset SHALL require a full rise, fall, rise sequence. The partial first period SHALL never be reported.

Reset
REQ-030 When reset is asserted, the FSM SHALL go to IDLE and all counters, the shadow register, the synchronizer and history flops, period, high_time, valid, overrun, stuck and stuck_level SHALL go to 0, at any time including mid-measurement.
REQ-031 After reset deasserts, the history flop SHALL start at 0, so a signal that is already high SHALL produce exactly one rise pulse.

Structure
REQ-032 The state encoding, the W and TIMEOUT defaults and the synchronizer depth SHALL live in the shared package pwm_meter_pkg.
REQ-033 The synchronizer and edge detector SHALL be the sub-module edge_sync, with ports clk, reset, d, q, rise and fall.

Verification
REQ-034 Square wave with 20 cycles high and 50-cycle period, ready=1 -> from the 2nd rise on, every result is period=50, high_time=20, with no overrun.
REQ-035 Same wave with ready=0 across two publishes -> valid holds, data equals the latest result, overrun=1; raising ready drops valid after 1 cycle.
REQ-036 signal held high for 5000 cycles with TIMEOUT=4095 -> stuck=1 and stuck_level=1 exactly 4095 cycles after the rise; no publish; the next fall returns the FSM to IDLE and stuck=0.
REQ-037 Reset pulsed in the middle of the HIGH phase -> all outputs 0; the first result appears only after a new full rise, fall, rise sequence.
REQ-038 en=0 for 10 cycles in the middle of the LOW phase -> the reported period is 10 less than the true period; valid and ready behave normally during the gap.
REQ-039 Publish and ready=1 in the same cycle with valid=1 -> the new data loads, valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/pwm_meter_pkg.sv
// rtl/pwm_meter_pkg.sv - shared types and defaults for the PWM width meter
// Purpose: FSM state encoding, default counter width and timeout, and the
//          synchronizer depth used by edge_sync.
// Ports:   none (package)
package pwm_meter_pkg;

  localparam int DEF_W       = 12;
  localparam int DEF_TIMEOUT = 4095;
  localparam int SYNC_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } meter_state_e;

endpackage

// File: rtl/pwm_width_meter_if.sv
// rtl/pwm_width_meter_if.sv - result handshake interface of the PWM width meter
// Purpose: groups the measurement result and its valid/ready handshake.
// Signals: period, high_time (W bits), valid (producer), ready (consumer).
// Modports: master = meter side, slave = consumer side.
interface pwm_width_meter_if
  import pwm_meter_pkg::*;
#(
  parameter int W = DEF_W
);

  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         ready;

  modport master (output period, output high_time, output valid, input ready);
  modport slave  (input period, input high_time, input valid, output ready);

endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - synchronizer and edge detector for the PWM input
// Purpose: brings the asynchronous PWM pad into clk and produces single-cycle
//          rise/fall pulses from a history flop.
// Ports:   clk, reset (async, active-high), d (async pad), q (synchronized
//          level), rise, fall (one-cycle pulses).
module edge_sync
  import pwm_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
      hist_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign q = sync_q[SYNC_DEPTH-1];
  // History starts at 0, so a pad already high out of reset yields one rise.
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/pwm_width_meter.sv
// rtl/pwm_width_meter.sv - PWM period and high-time meter with result handshake
// Purpose: measures rise-to-rise period and rise-to-fall high time of a PWM
//          signal, publishes both as one result, flags overrun and stuck input.
// Ports:   clk, reset (async, active-high), en (count enable), signal (async
//          PWM pad), res (master: period, high_time, valid, ready),
//          overrun (sticky), stuck (level), stuck_level (pad level when stuck).
module pwm_width_meter
  import pwm_meter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT  // must not exceed 2^W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              signal,
  pwm_width_meter_if.master res,
  output logic              overrun,
  output logic              stuck,
  output logic              stuck_level
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] TO_CNT  = W'(TIMEOUT);

  meter_state_e state_q, state_d;
  logic [W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, shadow_q, shadow_d;
  logic [W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic         valid_q, valid_d, overrun_q, overrun_d;
  logic         stuck_level_q, stuck_level_d;
  logic         sig_s, rise, fall, publish, xfer, timeout;
  logic [W-1:0] per_inc, hi_inc;

  edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (signal),
    .q     (sig_s),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating increments: counters park at all-ones instead of wrapping.
  assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + W'(1);
  assign hi_inc  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + W'(1);
  assign timeout = (per_cnt_q >= TO_CNT);
  assign xfer    = valid_q && res.ready;

  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    shadow_d      = shadow_q;
    stuck_level_d = stuck_level_q;
    publish       = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d   = HIGH;
            per_cnt_d = W'(1);
            hi_cnt_d  = W'(1);
          end
        end
        HIGH: begin
          // Timeout wins over an edge arriving in the same cycle.
          if (timeout) begin
            state_d       = STUCK;
            stuck_level_d = sig_s;
          end else if (fall) begin
            state_d   = LOW;
            shadow_d  = hi_cnt_q;
            per_cnt_d = per_inc;
          end else begin
            per_cnt_d = per_inc;
            hi_cnt_d  = hi_inc;
          end
        end
        LOW: begin
          if (timeout) begin
            state_d       = STUCK;
            stuck_level_d = sig_s;
          end else if (rise) begin
            state_d   = HIGH;
            publish   = 1'b1;
            per_cnt_d = W'(1);
            hi_cnt_d  = W'(1);
          end else begin
            per_cnt_d = per_inc;
          end
        end
        STUCK: begin
          if (rise) begin
            state_d   = HIGH;
            per_cnt_d = W'(1);
            hi_cnt_d  = W'(1);
          end else if (fall) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result register: a publish always loads; it only counts as an overrun
  // when the old result is still pending and not leaving this same cycle.
  always_comb begin
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (publish) begin
      period_d    = per_cnt_q;
      high_time_d = shadow_q;
      valid_d     = 1'b1;
      if (valid_q && !res.ready) overrun_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      shadow_q      <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      shadow_q      <= shadow_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign res.period    = period_q;
  assign res.high_time = high_time_q;
  assign res.valid     = valid_q;
  assign overrun       = overrun_q;
  assign stuck         = (state_q == STUCK);
  assign stuck_level   = stuck_level_q;

endmodule

// File: tb/tb_pwm_width_meter.sv
// tb/tb_pwm_width_meter.sv - scoreboard testbench for pwm_width_meter
module tb_pwm_width_meter;
  localparam int W        = 12;
  localparam int TIMEOUT  = 4095;
  localparam int RISE_LAT = 3;

  typedef struct {
    int per;
    int hi;
  } res_t;

  logic clk = 1'b0;
  logic reset, en, signal;
  logic overrun, stuck, stuck_level;

  pwm_width_meter_if #(.W(W)) res_if ();

  pwm_width_meter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .signal      (signal),
    .res         (res_if),
    .overrun     (overrun),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   en_low = 0;
  res_t exp_q[$];

  // Reference model state: event-level view of the pad waveform.
  bit sig_cur, seen_rise, seen_fall, hold_mode;
  int rise_t, rise_enlow, cur_hi;

  always @(posedge clk) begin
    cyc++;
    if (!en) en_low++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A result is the enabled time between rises, with the high time taken
  // from the fall in between; a rise without a prior rise+fall only starts.
  task automatic rise_event();
    if (seen_rise && seen_fall) begin
      res_t r;
      r.per = (cyc - rise_t) - (en_low - rise_enlow);
      r.hi  = cur_hi;
      // With ready held low, a newer result replaces the pending one.
      if (hold_mode && exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(r);
    end
    seen_rise  = 1'b1;
    seen_fall  = 1'b0;
    rise_t     = cyc;
    rise_enlow = en_low;
  endtask

  task automatic fall_event();
    if (seen_rise && !seen_fall) begin
      cur_hi    = (cyc - rise_t) - (en_low - rise_enlow);
      seen_fall = 1'b1;
    end
  endtask

  task automatic set_sig(input bit v);
    if (v && !sig_cur) rise_event();
    else if (!v && sig_cur) fall_event();
    signal  = v;
    sig_cur = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int per);
    set_sig(1'b1);
    wait_cyc(hi);
    set_sig(1'b0);
    wait_cyc(per - hi);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, res_if.valid, 0);
    check({tag, "_period"}, res_if.period, 0);
    check({tag, "_high_time"}, res_if.high_time, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_stuck"}, stuck, 0);
    check({tag, "_stuck_level"}, stuck_level, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(1);
    @(negedge clk);
    check_zero("in_reset");
    @(posedge clk);
    #1;
    check("drain_before_reset", exp_q.size(), 0);
    exp_q.delete();
    seen_rise = 1'b0;
    seen_fall = 1'b0;
    hold_mode = 1'b0;
    reset     = 1'b0;
    // A pad already high at release looks like a fresh rise.
    if (sig_cur) rise_event();
    @(negedge clk);
    check_zero("after_reset");
    wait_cyc(1);
  endtask

  always @(negedge clk) begin
    if (!reset && res_if.valid && res_if.ready) begin
      res_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got period=%0d high_time=%0d expected none",
                 res_if.period, res_if.high_time);
      end else begin
        e = exp_q.pop_front();
        check("result_period", res_if.period, e.per);
        check("result_high_time", res_if.high_time, e.hi);
      end
    end
  end

  initial begin
    reset        = 1'b1;
    en           = 1'b1;
    signal       = 1'b0;
    sig_cur      = 1'b0;
    hold_mode    = 1'b0;
    res_if.ready = 1'b1;
    do_reset();

    // Fixed 20/50 square wave, then randomized widths and periods.
    for (int i = 0; i < 5; i++) wave(20, 50);
    for (int i = 0; i < 12; i++) begin
      int hi;
      int per;
      hi  = int'($urandom_range(4, 120));
      per = hi + int'($urandom_range(4, 150));
      wave(hi, per);
    end

    // en low for 10 cycles mid-LOW, with the handshake completing in the gap.
    res_if.ready = 1'b0;
    set_sig(1'b1);
    wait_cyc(20);
    set_sig(1'b0);
    wait_cyc(10);
    en = 1'b0;
    wait_cyc(3);
    res_if.ready = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check("valid_after_gap_xfer", res_if.valid, 0);
    wait_cyc(4);
    en = 1'b1;
    wait_cyc(10);
    wave(20, 50);
    wave(20, 50);
    set_sig(1'b1);
    wait_cyc(20);
    set_sig(1'b0);
    wait_cyc(20);
    check("no_overrun_ready_high", overrun, 0);
    check("no_stuck_normal", stuck, 0);

    // Two publishes while ready is low: latest data kept, overrun set.
    do_reset();
    res_if.ready = 1'b0;
    hold_mode    = 1'b1;
    wave(20, 50);
    wave(20, 50);
    wave(20, 60);
    set_sig(1'b1);
    wait_cyc(20);
    set_sig(1'b0);
    wait_cyc(20);
    @(negedge clk);
    check("hold_valid", res_if.valid, 1);
    check("hold_period_latest", res_if.period, 60);
    check("hold_high_latest", res_if.high_time, 20);
    check("hold_overrun", overrun, 1);
    wait_cyc(1);
    hold_mode    = 1'b0;
    res_if.ready = 1'b1;
    @(negedge clk);
    check("xfer_cycle_valid", res_if.valid, 1);
    wait_cyc(1);
    @(negedge clk);
    check("valid_drop_after_xfer", res_if.valid, 0);
    check("overrun_sticky", overrun, 1);
    wait_cyc(1);

    // Publish coinciding with a transfer of the pending result.
    do_reset();
    res_if.ready = 1'b0;
    wave(20, 50);
    wave(15, 45);
    set_sig(1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    res_if.ready = 1'b1;
    @(posedge clk);
    #1;
    res_if.ready = 1'b0;
    @(negedge clk);
    check("same_cycle_valid", res_if.valid, 1);
    check("same_cycle_overrun", overrun, 0);
    check("same_cycle_period", res_if.period, 45);
    check("same_cycle_high", res_if.high_time, 15);
    wait_cyc(14);
    set_sig(1'b0);
    res_if.ready = 1'b1;
    wait_cyc(10);

    // Reset in the middle of a HIGH phase.
    do_reset();
    wave(20, 50);
    wave(20, 50);
    set_sig(1'b1);
    wait_cyc(8);
    do_reset();
    wait_cyc(8);
    set_sig(1'b0);
    wait_cyc(30);
    wave(20, 50);
    set_sig(1'b1);
    wait_cyc(20);
    set_sig(1'b0);
    wait_cyc(30);

    // Pad stuck high past the timeout.
    do_reset();
    set_sig(1'b1);
    repeat (RISE_LAT + TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    check("stuck_not_yet", stuck, 0);
    @(posedge clk);
    @(negedge clk);
    check("stuck_set", stuck, 1);
    check("stuck_level_high", stuck_level, 1);
    check("stuck_no_publish", res_if.valid, 0);
    seen_rise = 1'b0;  // the abandoned measurement never reports
    wait_cyc(5000 - (RISE_LAT + TIMEOUT) - 1);
    set_sig(1'b0);
    wait_cyc(10);
    @(negedge clk);
    check("stuck_cleared_by_fall", stuck, 0);
    wait_cyc(1);
    wave(20, 50);
    wave(20, 50);
    set_sig(1'b1);
    wait_cyc(20);
    set_sig(1'b0);
    wait_cyc(20);
    check("stuck_phase_no_overrun", overrun, 0);

    check("drain_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
